// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 pipeline: widths, ALU op classes and
// the packed control word carried between stages.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // ALU operation class produced by the main decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;  // loads/stores, address add
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;  // branch compare
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;  // decode Funct field

    // Decoded control word: seven side-effect bits plus the ALU op class
    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // An invalid instruction must not write registers, memory or redirect
    // the PC, so the seven side-effect bits are cleared; the ALU op class is
    // harmless and passes through unchanged.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
        ctrl_t g;
        g = c;
        if (!valid) begin
            g           = CTRL_NOP;
            g.alu_op    = c.alu_op;
        end
        return g;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: ID-side inputs, hazard controls and EX-side outputs.
// master = ID stage / hazard unit side, slave = the pipeline register.
interface id_ex_pipe_reg_if;
    import mips_pkg::*;

    logic                  hold;
    logic                  flush;

    logic                  id_valid;
    logic                  id_RegWrite;
    logic                  id_MemtoReg;
    logic                  id_Branch;
    logic                  id_MemRead;
    logic                  id_MemWrite;
    logic                  id_RegDst;
    logic                  id_ALUSrc;
    logic                  id_ALU_Op1;
    logic                  id_ALU_Op2;
    logic [DATA_W-1:0]     id_pc4;
    logic [DATA_W-1:0]     id_rd1;
    logic [DATA_W-1:0]     id_rd2;
    logic [DATA_W-1:0]     id_imm;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;

    logic                  ex_valid;
    logic                  ex_RegWrite;
    logic                  ex_MemtoReg;
    logic                  ex_Branch;
    logic                  ex_MemRead;
    logic                  ex_MemWrite;
    logic                  ex_RegDst;
    logic                  ex_ALUSrc;
    logic                  ALU_Op1;
    logic                  ALU_Op2;
    logic [5:0]            Funct;
    logic [DATA_W-1:0]     ex_pc4;
    logic [DATA_W-1:0]     ex_rd1;
    logic [DATA_W-1:0]     ex_rd2;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;

    modport master (
        output hold, flush, id_valid,
               id_RegWrite, id_MemtoReg, id_Branch, id_MemRead, id_MemWrite,
               id_RegDst, id_ALUSrc, id_ALU_Op1, id_ALU_Op2,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
        input  ex_valid,
               ex_RegWrite, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite,
               ex_RegDst, ex_ALUSrc, ALU_Op1, ALU_Op2, Funct,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd
    );

    modport slave (
        input  hold, flush, id_valid,
               id_RegWrite, id_MemtoReg, id_Branch, id_MemRead, id_MemWrite,
               id_RegDst, id_ALUSrc, id_ALU_Op1, id_ALU_Op2,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
        output ex_valid,
               ex_RegWrite, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite,
               ex_RegDst, ex_ALUSrc, ALU_Op1, ALU_Op2, Funct,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd
    );

endinterface

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async clear, flush-to-zero (bubble),
// hold (stall) and otherwise load. Flush beats hold.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Field storage with priority reset > flush > hold > load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register of the 5-stage MIPS-32 core. Three field groups
// (control+valid, data, register specifiers) share the same hold/flush
// behaviour; Funct is taken straight from the registered immediate.
module id_ex_pipe_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    id_ex_pipe_reg_if.slave bus
);

    localparam int CTRL_W = 1 + $bits(ctrl_t);
    localparam int DATA_GRP_W = 4 * DATA_W;
    localparam int SPEC_GRP_W = 3 * REG_ADDR_W;

    ctrl_t                 id_ctrl_raw;
    ctrl_t                 id_ctrl;
    ctrl_t                 ex_ctrl;
    logic                  ex_valid_q;
    logic [CTRL_W-1:0]     ctrl_q;
    logic [DATA_GRP_W-1:0] data_q;
    logic [SPEC_GRP_W-1:0] spec_q;

    // Assemble the decoded control word and suppress side effects of bubbles
    always_comb begin
        id_ctrl_raw           = CTRL_NOP;
        id_ctrl_raw.reg_write = bus.id_RegWrite;
        id_ctrl_raw.memto_reg = bus.id_MemtoReg;
        id_ctrl_raw.branch    = bus.id_Branch;
        id_ctrl_raw.mem_read  = bus.id_MemRead;
        id_ctrl_raw.mem_write = bus.id_MemWrite;
        id_ctrl_raw.reg_dst   = bus.id_RegDst;
        id_ctrl_raw.alu_src   = bus.id_ALUSrc;
        id_ctrl_raw.alu_op    = {bus.id_ALU_Op1, bus.id_ALU_Op2};
        id_ctrl               = gate_ctrl(id_ctrl_raw, bus.id_valid);
    end

    pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .hold  (bus.hold),
        .flush (bus.flush),
        .d     ({bus.id_valid, id_ctrl}),
        .q     (ctrl_q)
    );

    pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .hold  (bus.hold),
        .flush (bus.flush),
        .d     ({bus.id_pc4, bus.id_rd1, bus.id_rd2, bus.id_imm}),
        .q     (data_q)
    );

    pipe_field_reg #(.W(SPEC_GRP_W)) u_spec_reg (
        .clk   (clk),
        .reset (reset),
        .hold  (bus.hold),
        .flush (bus.flush),
        .d     ({bus.id_rs, bus.id_rt, bus.id_rd}),
        .q     (spec_q)
    );

    assign ex_valid_q = ctrl_q[CTRL_W-1];
    assign ex_ctrl    = ctrl_t'(ctrl_q[CTRL_W-2:0]);

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_RegWrite = ex_ctrl.reg_write;
    assign bus.ex_MemtoReg = ex_ctrl.memto_reg;
    assign bus.ex_Branch   = ex_ctrl.branch;
    assign bus.ex_MemRead  = ex_ctrl.mem_read;
    assign bus.ex_MemWrite = ex_ctrl.mem_write;
    assign bus.ex_RegDst   = ex_ctrl.reg_dst;
    assign bus.ex_ALUSrc   = ex_ctrl.alu_src;
    assign bus.ALU_Op1     = ex_ctrl.alu_op[1];
    assign bus.ALU_Op2     = ex_ctrl.alu_op[0];

    assign bus.ex_pc4 = data_q[4*DATA_W-1:3*DATA_W];
    assign bus.ex_rd1 = data_q[3*DATA_W-1:2*DATA_W];
    assign bus.ex_rd2 = data_q[2*DATA_W-1:DATA_W];
    assign bus.ex_imm = data_q[DATA_W-1:0];
    assign bus.Funct  = data_q[5:0];

    assign bus.ex_rs = spec_q[3*REG_ADDR_W-1:2*REG_ADDR_W];
    assign bus.ex_rt = spec_q[2*REG_ADDR_W-1:REG_ADDR_W];
    assign bus.ex_rd = spec_q[REG_ADDR_W-1:0];

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS-32 core.
- Captures the decoded control word, register operands, sign-extended immediate and register specifiers at the end of ID. Presents them to EX for one cycle.
- Its ALU_Op1, ALU_Op2 and Funct outputs drive the ALU control decoder directly.
- Supports hold (stall) and flush (bubble insertion), and carries a valid bit so EX/MEM/WB and the forwarding unit can ignore bubbles.

Parameters:
- DATA_W, 32, width of PC+4, register operands and immediate.
- REG_ADDR_W, 5, width of register specifiers rs/rt/rd.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- hold  input  1  keep current contents (downstream stall).
- flush  input  1  load a bubble this cycle (load-use hazard / taken branch).
- id_valid  input  1  ID stage holds a real instruction.
- id_RegWrite, id_MemtoReg, id_Branch, id_MemRead, id_MemWrite, id_RegDst, id_ALUSrc  input  1 each  decoded control bits.
- id_ALU_Op1, id_ALU_Op2  input  1 each  ALU operation class from main decoder.
- id_pc4  input  DATA_W  PC+4 of instruction in ID.
- id_rd1, id_rd2  input  DATA_W  register file read data.
- id_imm  input  DATA_W  sign-extended immediate.
- id_rs, id_rt, id_rd  input  REG_ADDR_W  register specifiers.
- ex_valid  output  1  EX holds a real instruction.
- ex_RegWrite … ex_ALUSrc  output  1 each  registered control bits (same set as inputs).
- ALU_Op1, ALU_Op2  output  1 each  registered ALU op class to ALU control.
- Funct  output  6  equals registered ex_imm[5:0].
- ex_pc4, ex_rd1, ex_rd2, ex_imm  output  DATA_W  registered data.
- ex_rs, ex_rt, ex_rd  output  REG_ADDR_W  registered specifiers.

Behaviour:
- Reset (async, reset=1): every output is 0 immediately, including ex_valid, all control bits, ALU_Op1/ALU_Op2 (=00, add), Funct, data and specifiers. Outputs are held at 0 while reset is asserted.
- Priority each rising edge, first match wins: reset > flush > hold > load.
- flush=1: bubble load. ex_valid=0. All seven control bits=0. ALU_Op1/ALU_Op2=00. Data and specifier fields=0. flush overrides a simultaneous hold.
- hold=1, flush=0: all registers keep their value. id_* is ignored.
- Otherwise (load): every ex_* output takes its id_* input. ex_valid=id_valid.
- Gating on id_valid=0: when loading with id_valid=0, the seven control bits are forced to 0 regardless of id_* values, so no architectural side effect is possible. Data fields still load.
- Latency: exactly 1 cycle from ID input to EX output. No combinational path from id_* to outputs.
- Funct is not separately stored; it is always ex_imm[5:0]. A bubble therefore gives Funct=000000.
- Reset deassertion mid-stream: the first edge after deassertion performs a normal flush/hold/load evaluation. No extra bubble is inserted.
- Hold over multiple cycles: contents stay stable indefinitely. Releasing hold loads the current id_* on the next edge.

Decomposition:
- Shared package mips_pkg:
  - DATA_W, REG_ADDR_W.
  - ALU_OP encodings (00 add/mem, 01 sub/branch, 10 R-type).
  - A packed control-word typedef, ctrl_t, holding the seven control bits plus the 2-bit ALU op, with a CTRL_NOP constant of all zeros.
- One natural sub-module: pipe_field_reg. A parameterised-width register with async reset, flush-to-zero and hold, instantiated per field group: control, data, specifiers.

Test Plan:
- Reset: assert reset mid-cycle with all id_* = all-ones -> all outputs 0 immediately. After release with no edge, outputs stay 0.
- Load: id_valid=1, R-type add (ALU_Op1=1, ALU_Op2=0, id_imm=0x00000020, RegWrite=1, RegDst=1, rs=1, rt=2, rd=3) -> next edge: ALU_Op1/ALU_Op2=10, Funct=100000, ex_valid=1, ex_rd=3.
- Hold: after the load, change id_* to an lw (id_imm=0xFFFFFFFC), hold=1 for 3 cycles -> outputs unchanged (Funct=100000). Release hold -> next edge ex_imm=0xFFFFFFFC, Funct=111100, MemRead=1.
- Flush overrides hold: flush=1 and hold=1 with valid sub (ALU_Op2=1) at input -> next edge ex_valid=0, all controls 0, ALU_Op1/ALU_Op2=00, Funct=000000.
- Invalid input gating: id_valid=0 with id_MemWrite=1, id_RegWrite=1, id_rd1=0x12345678 -> ex_valid=0, MemWrite=0, RegWrite=0, ex_rd1=0x12345678.
- Back-to-back stream: 4 consecutive instructions with no hold/flush -> each appears on outputs exactly one cycle after its input. Then a flush in cycle 3 -> bubble in cycle 4 only, and the next instruction follows normally.
